oaram_rle_compressor: RTL and testbench



---
 rtl/oaram_rle_compressor_pkg.sv | 19 +
 rtl/oaram_rle_compressor_rle_run_encoder.sv | 34 +++
 rtl/oaram_rle_compressor.sv | 165 ++++++++++++++++
 tb/tb_oaram_rle_compressor.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oaram_rle_compressor_pkg.sv
// Shared definitions for the OARAM run-length compressor: entry layout,
// zero-run limits and FSM state encoding.
package oaram_rle_compressor_pkg;

  localparam int unsigned bits_of_indices = 4;
  localparam int unsigned MAX_RUN         = (1 << bits_of_indices) - 1;

  typedef struct packed {
    logic signed [15:0]            data;
    logic [bits_of_indices-1:0]    index;
  } oaram_entry_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_FLUSH
  } state_t;

endpackage

// File: rtl/oaram_rle_compressor_rle_run_encoder.sv
// Combinational zero-run encoder: decides whether a dense beat produces a
// compressed entry (nonzero value or full-run marker entry) and the next run.
// Optional build macro: OARAM_RLE_RELU_EN folds a ReLU into the zero test.
module rle_run_encoder #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned IDX_W  = 4
) (
  input  logic signed [DATA_W-1:0] in_data,
  input  logic [IDX_W-1:0]         run,
  output logic                     emit,
  output logic signed [DATA_W-1:0] ent_data,
  output logic [IDX_W-1:0]         ent_index,
  output logic [IDX_W-1:0]         next_run
);

  logic signed [DATA_W-1:0] data_eff;
  logic                     is_zero;
  logic                     run_full;

  // Emit on nonzero data, or on a zero that would overflow the run field.
  always_comb begin
    data_eff = in_data;
`ifdef OARAM_RLE_RELU_EN
    if (in_data[DATA_W-1]) data_eff = '0;
`endif
    is_zero   = (data_eff == '0);
    run_full  = (run == '1);
    emit      = !is_zero || run_full;
    ent_data  = data_eff;
    ent_index = run;
    next_run  = emit ? '0 : run + 1'b1;
  end

endmodule

// File: rtl/oaram_rle_compressor.sv
// OARAM RLE compressor top: accepts the dense PPU stream, emits
// (value, zero-run) entries with their OARAM address, and reports the
// per-channel entry count. Optional build macro: OARAM_RLE_RELU_EN.
module oaram_rle_compressor
  import oaram_rle_compressor_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned IDX_W  = bits_of_indices,
  parameter int unsigned CNT_W  = 10,
  parameter int unsigned CH_W   = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_last,
  input  logic [CH_W-1:0]          in_ch,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]         out_index,
  output logic [CNT_W-1:0]         out_addr,
  output logic [CH_W-1:0]          out_ch,
  output logic                     ch_done,
  output logic [CNT_W-1:0]         ch_count,
  output logic [CH_W-1:0]          ch_count_ch,
  output logic                     ovf
);

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         run_q, run_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [CH_W-1:0]          ch_q, ch_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [DATA_W-1:0] out_data_q, out_data_d;
  logic [IDX_W-1:0]         out_index_q, out_index_d;
  logic [CNT_W-1:0]         out_addr_q, out_addr_d;
  logic [CH_W-1:0]          out_ch_q, out_ch_d;
  logic                     ch_done_q, ch_done_d;
  logic [CNT_W-1:0]         ch_count_q, ch_count_d;
  logic [CH_W-1:0]          ch_count_ch_q, ch_count_ch_d;
  logic                     ovf_q, ovf_d;

  logic                     enc_emit;
  logic signed [DATA_W-1:0] enc_data;
  logic [IDX_W-1:0]         enc_index;
  logic [IDX_W-1:0]         enc_next_run;
  logic                     out_free;
  logic                     accept;

  rle_run_encoder #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_enc (
    .in_data   (in_data),
    .run       (run_q),
    .emit      (enc_emit),
    .ent_data  (enc_data),
    .ent_index (enc_index),
    .next_run  (enc_next_run)
  );

  // Output register is free when empty or being drained this cycle.
  always_comb begin
    out_free = !out_valid_q || out_ready;
    in_ready = !rst && (state_q != S_FLUSH) && out_free;
    accept   = in_valid && in_ready;
  end

  // Next-state: FSM, run/entry counters, output register and channel report.
  always_comb begin
    state_d       = state_q;
    run_d         = run_q;
    cnt_d         = cnt_q;
    ch_d          = ch_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_index_d   = out_index_q;
    out_addr_d    = out_addr_q;
    out_ch_d      = out_ch_q;
    ch_done_d     = 1'b0;
    ch_count_d    = ch_count_q;
    ch_count_ch_d = ch_count_ch_q;
    ovf_d         = ovf_q;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    case (state_q)
      S_IDLE, S_ACTIVE: begin
        if (accept) begin
          if (state_q == S_IDLE) ch_d = in_ch;
          run_d = enc_next_run;
          if (enc_emit) begin
            // A new entry overwrites a register being drained in the same cycle.
            out_valid_d = 1'b1;
            out_data_d  = enc_data;
            out_index_d = enc_index;
            out_addr_d  = cnt_q;
            out_ch_d    = (state_q == S_IDLE) ? in_ch : ch_q;
            if (cnt_q == '1) ovf_d = 1'b1;
            else             cnt_d = cnt_q + 1'b1;
          end
          state_d = in_last ? S_FLUSH : S_ACTIVE;
        end
      end
      S_FLUSH: begin
        // Report only once the channel's final entry has been handed off.
        if (out_free) begin
          ch_done_d     = 1'b1;
          ch_count_d    = cnt_q;
          ch_count_ch_d = ch_q;
          run_d         = '0;
          cnt_d         = '0;
          state_d       = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      run_q         <= '0;
      cnt_q         <= '0;
      ch_q          <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_index_q   <= '0;
      out_addr_q    <= '0;
      out_ch_q      <= '0;
      ch_done_q     <= 1'b0;
      ch_count_q    <= '0;
      ch_count_ch_q <= '0;
      ovf_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      run_q         <= run_d;
      cnt_q         <= cnt_d;
      ch_q          <= ch_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_index_q   <= out_index_d;
      out_addr_q    <= out_addr_d;
      out_ch_q      <= out_ch_d;
      ch_done_q     <= ch_done_d;
      ch_count_q    <= ch_count_d;
      ch_count_ch_q <= ch_count_ch_d;
      ovf_q         <= ovf_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_index   = out_index_q;
  assign out_addr    = out_addr_q;
  assign out_ch      = out_ch_q;
  assign ch_done     = ch_done_q;
  assign ch_count    = ch_count_q;
  assign ch_count_ch = ch_count_ch_q;
  assign ovf         = ovf_q;

endmodule

// File: tb/tb_oaram_rle_compressor.sv
// Self-checking bench for oaram_rle_compressor: table of dense beats with
// hand-derived entries, scoreboard queues for entries and channel reports,
// plus hand-written stall, reset-abort and count-saturation sequences.
module tb_oaram_rle_compressor;
  import oaram_rle_compressor_pkg::*;

  logic               clk, rst;
  logic               in_valid, in_ready, in_last;
  logic signed [15:0] in_data;
  logic [2:0]         in_ch;
  logic               out_valid, out_ready;
  logic signed [15:0] out_data;
  logic [3:0]         out_index;
  logic [9:0]         out_addr;
  logic [2:0]         out_ch;
  logic               ch_done;
  logic [9:0]         ch_count;
  logic [2:0]         ch_count_ch;
  logic               ovf;

  oaram_rle_compressor #(.DATA_W(16), .IDX_W(4), .CNT_W(10), .CH_W(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .in_ch(in_ch),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_addr(out_addr), .out_ch(out_ch),
    .ch_done(ch_done), .ch_count(ch_count), .ch_count_ch(ch_count_ch), .ovf(ovf)
  );

  typedef struct {
    logic signed [15:0] d;
    bit                 last;
    logic [2:0]         ch;
    bit                 emit;
    logic signed [15:0] ed;
    logic [3:0]         ei;
  } beat_t;

  typedef struct {
    oaram_entry_t e;
    logic [9:0]   addr;
    logic [2:0]   ch;
  } exp_t;

  typedef struct {
    logic [9:0] cnt;
    logic [2:0] ch;
  } done_t;

  beat_t  tbl[$];
  exp_t   exp_q[$];
  done_t  done_q[$];

  int     errors = 0;
  int     checks = 0;
  int     ready_mode = 0;
  int     cyc = 0;
  logic [9:0] exp_cnt = '0;
  logic [2:0] cur_ch  = '0;
  bit     first = 1'b1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // out_ready pattern: 0 always ready, 1 toggling 1,0,0,1, 2 never ready.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      case (ready_mode)
        1:       out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        2:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Monitor: sampled shortly before each rising edge.
  bit                 held = 1'b0;
  logic [32:0]        held_v;
  initial begin
    exp_t  e;
    done_t d;
    forever begin
      @(negedge clk);
      #3;
      if (rst) begin
        held = 1'b0;
      end else begin
        if (held) check("stall_hold", {out_valid, out_data, out_index, out_addr, out_ch}, {1'b1, held_v});
        if (out_valid && !out_ready) begin
          check("in_ready_stall", 64'(in_ready), 64'd0);
          held   = 1'b1;
          held_v = {out_data, out_index, out_addr, out_ch};
        end else begin
          held = 1'b0;
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_entry: got data=%0d idx=%0d addr=%0d ch=%0d expected none",
                     out_data, out_index, out_addr, out_ch);
          end else begin
            e = exp_q.pop_front();
            check("entry", {out_data, out_index, out_addr, out_ch}, {e.e.data, e.e.index, e.addr, e.ch});
          end
        end
        if (ch_done) begin
          if (done_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_ch_done: got count=%0d ch=%0d expected none", ch_count, ch_count_ch);
          end else begin
            d = done_q.pop_front();
            check("ch_count", {ch_count, ch_count_ch}, {d.cnt, d.ch});
          end
        end
      end
    end
  end

  function automatic void add(input int d, input bit last, input int ch,
                              input bit emit, input int ed, input int ei);
    beat_t b;
    b.d = 16'(d); b.last = last; b.ch = 3'(ch);
    b.emit = emit; b.ed = 16'(ed); b.ei = 4'(ei);
    tbl.push_back(b);
  endfunction

  // Drive one beat; push expectations at the cycle it is accepted.
  task automatic send(input beat_t b);
    exp_t  e;
    done_t dn;
    int    tries = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = b.d; in_last = b.last; in_ch = b.ch;
    forever begin
      #1;
      if (in_ready) begin
        if (first) begin cur_ch = b.ch; first = 1'b0; end
        if (b.emit) begin
          e.e.data = b.ed; e.e.index = b.ei; e.addr = exp_cnt; e.ch = cur_ch;
          exp_q.push_back(e);
          if (exp_cnt != 10'h3FF) exp_cnt = exp_cnt + 10'd1;
        end
        if (b.last) begin
          dn.cnt = exp_cnt; dn.ch = cur_ch;
          done_q.push_back(dn);
          exp_cnt = '0; first = 1'b1;
        end
        @(posedge clk);
        break;
      end
      tries++;
      if (tries > 200) begin
        checks++; errors++;
        $display("FAIL in_ready_timeout: got in_ready=0 expected 1 within 200 cycles");
        @(posedge clk);
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    while (exp_q.size() != 0 || done_q.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 3000) begin
        checks++; errors++;
        $display("FAIL drain_timeout: got %0d entries %0d reports pending expected 0",
                 exp_q.size(), done_q.size());
        exp_q.delete(); done_q.delete();
      end
    end
    repeat (4) @(negedge clk);
  endtask

  function automatic beat_t mk(input int d, input bit last, input int ch,
                               input bit emit, input int ed, input int ei);
    beat_t b;
    b.d = 16'(d); b.last = last; b.ch = 3'(ch);
    b.emit = emit; b.ed = 16'(ed); b.ei = 4'(ei);
    return b;
  endfunction

  initial begin
    // Channel 2 (later beats carry a different in_ch to show latching).
    add(0, 0, 2, 0, 0, 0);
    add(0, 0, 7, 0, 0, 0);
    add(5, 0, 7, 1, 5, 2);
    add(0, 0, 7, 0, 0, 0);
    add(7, 0, 7, 1, 7, 1);
`ifdef OARAM_RLE_RELU_EN
    add(-3, 1, 7, 0, 0, 0);
`else
    add(-3, 1, 7, 1, -3, 0);
`endif
    // 17 zeros then 9: full-run entry after the 16th zero.
    for (int i = 0; i < 15; i++) add(0, 0, 3, 0, 0, 0);
    add(0, 0, 3, 1, 0, 15);
    add(0, 0, 3, 0, 0, 0);
    add(9, 1, 3, 1, 9, 1);
    // All-zero channel of 6.
    for (int i = 0; i < 5; i++) add(0, 0, 4, 0, 0, 0);
    add(0, 1, 4, 0, 0, 0);
    // Trailing zeros dropped.
    add(3, 0, 6, 1, 3, 0);
    add(0, 0, 6, 0, 0, 0);
    add(0, 1, 6, 0, 0, 0);
    // Negative value handling.
`ifdef OARAM_RLE_RELU_EN
    add(-2, 0, 1, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0);
    add(6, 1, 1, 1, 6, 2);
`else
    add(-2, 0, 1, 1, -2, 0);
    add(0, 0, 1, 0, 0, 0);
    add(6, 1, 1, 1, 6, 1);
`endif

    in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_ch = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #3;
    check("reset_outputs", {out_valid, ch_done, ovf, out_data, ch_count, in_ready},
          64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table vectors, back to back.
    for (int i = 0; i < tbl.size(); i++) send(tbl[i]);
    wait_idle();

    // Back-pressure: out_ready toggling 1,0,0,1.
    ready_mode = 1;
    for (int k = 1; k <= 4; k++) send(mk(k, k == 4, 5, 1, k, 0));
    wait_idle();
    ready_mode = 0;
    repeat (2) @(negedge clk);

    // Reset mid-channel with a pending, stalled entry.
    ready_mode = 2;
    repeat (2) @(negedge clk);
    send(mk(0, 0, 4, 0, 0, 0));
    send(mk(3, 0, 4, 0, 0, 0));
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #3;
    check("rst_abort", {out_valid, ch_done, in_ready}, 64'd0);
    @(negedge clk);
    rst = 1'b0; ready_mode = 0;
    exp_cnt = '0; first = 1'b1;
    repeat (2) @(negedge clk);
    send(mk(4, 1, 5, 1, 4, 0));
    wait_idle();

    // Entry-count saturation at 2^CNT_W-1.
    check("ovf_clear", 64'(ovf), 64'd0);
    for (int k = 0; k < 1025; k++) send(mk((k % 100) + 1, k == 1024, 1, 1, (k % 100) + 1, 0));
    wait_idle();
    check("ovf_set", 64'(ovf), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #3;
    check("ovf_rst", 64'(ovf), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
